// File: rtl/superos_input_pio_if.sv
// Avalon-MM register bus between the CPU (master) and the input PIO (slave).
// readdata is combinational from the slave, zero wait states.
interface superos_input_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/superos_input_pio.sv
// Input PIO: synchronizes and debounces an external bus, captures per-bit edges
// into a sticky RW1C register and raises a maskable level interrupt.
module superos_input_pio #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   superos_input_pio_if.slave   bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_a;
   logic [WIDTH-1:0] sync_s;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic             wr;
   logic             wr_mask;
   logic             wr_edge;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= '0;
         sync_s <= '0;
      end else begin
         sync_a <= in_port;
         sync_s <= sync_a;
      end
   end

   // A bit is accepted on the edge its synchronized value has disagreed with
   // the debounced value for DEBOUNCE_CYCLES consecutive samples.
   always_comb begin
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = (sync_s[i] != stable[i]) && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_s[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= '0;
      end else begin
         stable <= stable ^ accept;
      end
   end

   assign rise = accept & sync_s;
   assign fall = accept & ~sync_s;

   generate
      if (EDGE_TYPE == 0) begin : g_edge_rise
         assign edge_hit = rise;
      end else if (EDGE_TYPE == 1) begin : g_edge_fall
         assign edge_hit = fall;
      end else begin : g_edge_any
         assign edge_hit = rise | fall;
      end
   endgenerate

   assign wr      = bus.chipselect & ~bus.write_n;
   assign wr_mask = wr && (bus.address == 2'd2);
   assign wr_edge = wr && (bus.address == 2'd3);
   assign edge_clr = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

   // New edges are OR-ed after the clear so a same-cycle capture survives it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture <= '0;
      end else begin
         edge_capture <= (edge_capture & ~edge_clr) | edge_hit;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
      end else if (wr_mask) begin
         irq_mask <= bus.writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         2'd0:    bus.readdata[WIDTH-1:0] = stable;
         2'd1:    bus.readdata = '0;
         2'd2:    bus.readdata[WIDTH-1:0] = irq_mask;
         default: bus.readdata[WIDTH-1:0] = edge_capture;
      endcase
   end

   assign irq = |(edge_capture & irq_mask);

   generate
      if (WIDTH < 32) begin : g_unused_wd
         logic unused_wd;
         assign unused_wd = ^bus.writedata[31:WIDTH];
      end
   endgenerate

endmodule

// File: tb/tb_superos_input_pio.sv
// Bench for superos_input_pio: two instances (rising-only and any-edge) share
// stimulus and are compared every cycle against a behavioural model.
module tb_superos_input_pio;
   localparam int D = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] in_port = 8'h00;
   logic       cs = 1'b0;
   logic       wn = 1'b1;
   logic [31:0] wd = '0;
   logic [1:0] addr0 = 2'd0;
   logic [1:0] addr1 = 2'd0;
   logic       irq0;
   logic       irq1;

   superos_input_pio_if bi0 ();
   superos_input_pio_if bi1 ();

   assign bi0.chipselect = cs;
   assign bi0.write_n    = wn;
   assign bi0.writedata  = wd;
   assign bi0.address    = addr0;
   assign bi1.chipselect = cs;
   assign bi1.write_n    = wn;
   assign bi1.writedata  = wd;
   assign bi1.address    = addr1;

   superos_input_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bi0.slave), .in_port(in_port), .irq(irq0));
   superos_input_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bi1.slave), .in_port(in_port), .irq(irq1));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: s is the input two samples late; a bit is accepted once s has
   // disagreed with the debounced value for D consecutive samples.
   logic [7:0] m_s1, m_s2, m_stable, m_mask;
   logic [7:0] m_cap [2];
   logic [7:0] hist [D];
   int         hcnt;

   function automatic logic [7:0] m_accept();
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         logic ok;
         ok = (hcnt >= D - 1) && (m_s2[i] != m_stable[i]);
         for (int k = 0; k < D - 1; k++) begin
            if (hist[k][i] != m_s2[i]) ok = 1'b0;
         end
         r[i] = ok;
      end
      return r;
   endfunction

   function automatic logic [7:0] m_clr();
      return (cs && !wn && addr0 == 2'd3) ? wd[7:0] : 8'h00;
   endfunction

   function automatic logic [31:0] m_rd(input int j, input logic [1:0] a);
      case (a)
         2'd0:    return {24'b0, m_stable};
         2'd1:    return 32'b0;
         2'd2:    return {24'b0, m_mask};
         default: return {24'b0, m_cap[j]};
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_mask <= '0;
         m_cap[0] <= '0; m_cap[1] <= '0;
         for (int k = 0; k < D; k++) hist[k] <= '0;
         hcnt <= 0;
      end else begin
         m_cap[0] <= (m_cap[0] & ~m_clr()) | (m_accept() & m_s2);
         m_cap[1] <= (m_cap[1] & ~m_clr()) | m_accept();
         m_stable <= m_stable ^ m_accept();
         if (cs && !wn && addr0 == 2'd2) m_mask <= wd[7:0];
         hist[0] <= m_s2;
         for (int k = 1; k < D; k++) hist[k] <= hist[k-1];
         if (hcnt < D) hcnt <= hcnt + 1;
         m_s2 <= m_s1;
         m_s1 <= in_port;
      end
   end

   always @(negedge clk) begin
      chk("rd0",  bi0.readdata, m_rd(0, addr0));
      chk("rd1",  bi1.readdata, m_rd(1, addr1));
      chk("irq0", {31'b0, irq0}, {31'b0, |(m_cap[0] & m_mask)});
      chk("irq1", {31'b0, irq1}, {31'b0, |(m_cap[1] & m_mask)});
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cs = 1'b1; wn = 1'b0; addr0 = a; addr1 = a; wd = d;
      cyc(1);
      cs = 1'b0; wn = 1'b1;
   endtask

   task automatic rd_chk(input int j, input logic [1:0] a, input logic [31:0] exp,
                         input string name);
      if (j == 0) addr0 = a; else addr1 = a;
      #1;
      chk(name, (j == 0) ? bi0.readdata : bi1.readdata, exp);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(1);
      reset_n = 1'b1;
   endtask

   initial begin
      int hold;
      in_port = 8'hA5;
      cyc(3);
      rd_chk(0, 2'd0, 32'h0, "reset_data");
      rd_chk(0, 2'd3, 32'h0, "reset_edge");
      chk("reset_irq", {31'b0, irq0}, 32'h0);

      // 0xA5 held from release: first sample edge k, DATA changes at k+17
      reset_n = 1'b1;
      repeat (17) @(posedge clk);
      #2;
      rd_chk(0, 2'd0, 32'h00, "a5_data_k16");
      @(posedge clk);
      #2;
      rd_chk(0, 2'd0, 32'hA5, "a5_data_k17");
      rd_chk(0, 2'd3, 32'hA5, "a5_edge0");
      rd_chk(1, 2'd3, 32'hA5, "a5_edge1");
      cyc(1);

      // 15-cycle glitch on bit 0 is discarded
      in_port = 8'h00;
      do_reset();
      cyc(20);
      in_port = 8'h01;
      cyc(15);
      in_port = 8'h00;
      cyc(25);
      rd_chk(0, 2'd0, 32'h0, "glitch_data");
      rd_chk(0, 2'd3, 32'h0, "glitch_edge0");
      rd_chk(1, 2'd3, 32'h0, "glitch_edge1");

      // bit 3 rise with mask, then clear
      wr(2'd2, 32'h08);
      in_port = 8'h08;
      cyc(20);
      rd_chk(0, 2'd3, 32'h08, "b3_edge");
      chk("b3_irq", {31'b0, irq0}, 32'h1);
      wr(2'd3, 32'h08);
      rd_chk(0, 2'd3, 32'h00, "b3_cleared");
      chk("b3_irq_off", {31'b0, irq0}, 32'h0);

      // partial RW1C and set-wins
      in_port = 8'h00;
      cyc(20);
      wr(2'd3, 32'hFF);
      in_port = 8'h0C;
      cyc(20);
      rd_chk(0, 2'd3, 32'h0C, "edge_0c");
      wr(2'd3, 32'h04);
      rd_chk(0, 2'd3, 32'h08, "rw1c_partial");
      in_port = 8'h08;
      cyc(20);
      rd_chk(0, 2'd3, 32'h08, "b2_fall_rise_only");
      in_port = 8'h0C;
      cyc(17);
      wr(2'd3, 32'h04);
      rd_chk(0, 2'd3, 32'h0C, "set_wins");
      rd_chk(0, 2'd0, 32'h0C, "set_wins_data");

      // bit 7 falling edge: captured only by the any-edge instance
      wr(2'd3, 32'hFF);
      in_port = 8'h8C;
      cyc(20);
      wr(2'd3, 32'hFF);
      in_port = 8'h0C;
      cyc(20);
      rd_chk(0, 2'd3, 32'h00, "fall_b7_rise_only");
      rd_chk(1, 2'd3, 32'h80, "fall_b7_any");

      // reset mid-debounce with everything set
      in_port = 8'h00;
      cyc(20);
      in_port = 8'hFF;
      cyc(20);
      wr(2'd2, 32'hFF);
      rd_chk(0, 2'd3, 32'hFF, "pre_rst_edge");
      chk("pre_rst_irq", {31'b0, irq0}, 32'h1);
      in_port = 8'h3C;
      cyc(8);
      do_reset();
      rd_chk(0, 2'd0, 32'h0, "rst_data");
      rd_chk(0, 2'd2, 32'h0, "rst_mask");
      rd_chk(0, 2'd3, 32'h0, "rst_edge");
      chk("rst_irq", {31'b0, irq0}, 32'h0);
      cyc(16);
      rd_chk(0, 2'd0, 32'h0, "rst_redeb_early");
      cyc(2);
      rd_chk(0, 2'd0, 32'h3C, "rst_redeb_done");

      // randomized phase, model checked every cycle
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            in_port = in_port ^ 8'($urandom);
            hold = $urandom_range(1, 40);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 5) == 0) begin
            cs = 1'b1; wn = 1'b0;
            addr0 = 2'($urandom); addr1 = addr0;
            wd = $urandom;
         end else begin
            cs = 1'($urandom); wn = 1'b1;
            addr0 = 2'($urandom); addr1 = 2'($urandom);
            wd = $urandom;
         end
         if (c == 1500) reset_n = 1'b0;
         if (c == 1502) reset_n = 1'b1;
         cyc(1);
      end
      cs = 1'b0; wn = 1'b1;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
